// File: rtl/issue_queue_4e_pkg.sv
// issue_queue_4e_pkg: shared widths, entry payload types and the wakeup/slot helpers
package issue_queue_4e_pkg;
  localparam int ROB_W = 4;
  localparam int DATA_W = 32;
  localparam int ISSUE_ENTRIES = 4;
  typedef struct packed {
    logic [ROB_W-1:0] rob;
    logic rdy;
    logic [DATA_W-1:0] value;
  } src_t;
  typedef struct packed {
    src_t src0;
    src_t src1;
    logic [ROB_W-1:0] dst_rob;
    logic branch;
    logic load;
    logic store;
    logic pipe_alu;
    logic pipe_mul;
    logic pipe_mem;
    logic pipe_bru;
    logic [1:0] bp_pattern;
    logic bp_taken;
    logic bp_hit;
    logic [DATA_W-1:0] bp_target;
  } entry_t;
  function automatic int slot_lo(int k, int w);
    return k * w;
  endfunction
  // A waiting operand whose producer tag matches the broadcast captures the value; ready operands are never overwritten.
  function automatic src_t wake(src_t s, logic wv, logic [ROB_W-1:0] wr, logic [DATA_W-1:0] wd);
    src_t r;
    r = s;
    if (!s.rdy && wv && s.rob == wr) begin
      r.rdy = 1'b1;
      r.value = wd;
    end
    return r;
  endfunction
endpackage

// File: rtl/issue_queue_4e_if.sv
// issue_queue_4e_if: dispatch/writeback/pick bundle; master = dispatch+pick side, slave = queue
interface issue_queue_4e_if;
  import issue_queue_4e_pkg::*;
  localparam int N = ISSUE_ENTRIES;
  logic flush;
  logic enq_valid;
  logic enq_ready;
  entry_t enq;
  logic wb_valid;
  logic [ROB_W-1:0] wb_rob;
  logic [DATA_W-1:0] wb_value;
  logic [N-1:0] issue_en;
  logic [N-1:0] valid;
  logic [N*ROB_W-1:0] src0_rob, src1_rob, dst_rob;
  logic [N-1:0] src0_rdy, src1_rdy;
  logic [N*DATA_W-1:0] src0_value, src1_value, bp_target;
  logic [N-1:0] branch, load, store;
  logic [N-1:0] pipe_alu, pipe_mul, pipe_mem, pipe_bru;
  logic [2*N-1:0] bp_pattern;
  logic [N-1:0] bp_taken, bp_hit;
  logic [2:0] count;
  modport master (
    output flush, enq_valid, enq, wb_valid, wb_rob, wb_value, issue_en,
    input enq_ready, valid, src0_rob, src0_rdy, src0_value, src1_rob, src1_rdy, src1_value,
    dst_rob, branch, load, store, pipe_alu, pipe_mul, pipe_mem, pipe_bru,
    bp_pattern, bp_taken, bp_hit, bp_target, count
  );
  modport slave (
    input flush, enq_valid, enq, wb_valid, wb_rob, wb_value, issue_en,
    output enq_ready, valid, src0_rob, src0_rdy, src0_value, src1_rob, src1_rdy, src1_value,
    dst_rob, branch, load, store, pipe_alu, pipe_mul, pipe_mem, pipe_bru,
    bp_pattern, bp_taken, bp_hit, bp_target, count
  );
endinterface

// File: rtl/issue_queue_4e_entry.sv
// issue_queue_4e_entry: one slot (valid + payload) with operand wakeup; ports we/clr/flush, wb bus, enq payload -> valid, ent
import issue_queue_4e_pkg::*;
module issue_queue_4e_entry (
  input  logic clk,
  input  logic reset,
  input  logic we,
  input  logic clr,
  input  logic flush,
  input  logic wb_valid,
  input  logic [ROB_W-1:0] wb_rob,
  input  logic [DATA_W-1:0] wb_value,
  input  entry_t enq,
  output logic valid,
  output entry_t ent
);
  entry_t nxt;
  // The same capture applies to a fresh enqueue (bypass) and to a resident entry (wakeup).
  always_comb begin
    nxt = we ? enq : ent;
    nxt.src0 = wake(nxt.src0, wb_valid, wb_rob, wb_value);
    nxt.src1 = wake(nxt.src1, wb_valid, wb_rob, wb_value);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      valid <= 1'b0;
      ent <= '0;
    end else begin
      valid <= flush ? 1'b0 : we ? 1'b1 : clr ? 1'b0 : valid;
      if (!flush && (we || valid)) ent <= nxt;
    end
endmodule

// File: rtl/issue_queue_4e.sv
// issue_queue_4e: 4-entry issue queue; ports clk, reset, bus (slave: dispatch in, wb broadcast, pick enables, packed slot state out)
import issue_queue_4e_pkg::*;
module issue_queue_4e (
  input logic clk,
  input logic reset,
  issue_queue_4e_if.slave bus
);
  localparam int N = ISSUE_ENTRIES;
  logic [N-1:0] valid, free, sel, we;
  entry_t ent [N];
  assign bus.enq_ready = ~&valid;
  assign free = ~valid;
  // Isolate the lowest set bit of free: the lowest-index empty slot.
  assign sel = free & (-free);
  assign we = {N{bus.enq_valid & bus.enq_ready}} & sel;
  assign bus.valid = valid;
  assign bus.count = 3'($countones(valid));
  for (genvar k = 0; k < N; k++) begin : g_slot
    issue_queue_4e_entry u_entry (
      .clk(clk), .reset(reset), .we(we[k]), .clr(bus.issue_en[k]), .flush(bus.flush),
      .wb_valid(bus.wb_valid), .wb_rob(bus.wb_rob), .wb_value(bus.wb_value),
      .enq(bus.enq), .valid(valid[k]), .ent(ent[k])
    );
    assign bus.src0_rob[slot_lo(k, ROB_W) +: ROB_W] = ent[k].src0.rob;
    assign bus.src0_rdy[k] = ent[k].src0.rdy;
    assign bus.src0_value[slot_lo(k, DATA_W) +: DATA_W] = ent[k].src0.value;
    assign bus.src1_rob[slot_lo(k, ROB_W) +: ROB_W] = ent[k].src1.rob;
    assign bus.src1_rdy[k] = ent[k].src1.rdy;
    assign bus.src1_value[slot_lo(k, DATA_W) +: DATA_W] = ent[k].src1.value;
    assign bus.dst_rob[slot_lo(k, ROB_W) +: ROB_W] = ent[k].dst_rob;
    assign bus.branch[k] = ent[k].branch;
    assign bus.load[k] = ent[k].load;
    assign bus.store[k] = ent[k].store;
    assign bus.pipe_alu[k] = ent[k].pipe_alu;
    assign bus.pipe_mul[k] = ent[k].pipe_mul;
    assign bus.pipe_mem[k] = ent[k].pipe_mem;
    assign bus.pipe_bru[k] = ent[k].pipe_bru;
    assign bus.bp_pattern[slot_lo(k, 2) +: 2] = ent[k].bp_pattern;
    assign bus.bp_taken[k] = ent[k].bp_taken;
    assign bus.bp_hit[k] = ent[k].bp_hit;
    assign bus.bp_target[slot_lo(k, DATA_W) +: DATA_W] = ent[k].bp_target;
  end
endmodule

// File: tb/tb_issue_queue_4e.sv
// tb_issue_queue_4e: directed self-checking bench for issue_queue_4e
module tb_issue_queue_4e;
  logic clk, reset;
  int checks, failures;
  issue_queue_4e_if q ();
  issue_queue_4e dut (.clk(clk), .reset(reset), .bus(q.slave));
  always #5 clk = ~clk;
  task automatic chk(string tag, logic [127:0] obs, logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic put(logic [3:0] dst, logic [3:0] r0, logic y0, logic [31:0] v0,
                     logic [3:0] r1, logic y1, logic [31:0] v1);
    q.enq = '0;
    q.enq.dst_rob = dst;
    q.enq.src0.rob = r0;
    q.enq.src0.rdy = y0;
    q.enq.src0.value = v0;
    q.enq.src1.rob = r1;
    q.enq.src1.rdy = y1;
    q.enq.src1.value = v1;
    q.enq.pipe_alu = 1'b1;
    q.enq_valid = 1'b1;
  endtask
  task automatic wb(logic [3:0] r, logic [31:0] v);
    q.wb_valid = 1'b1;
    q.wb_rob = r;
    q.wb_value = v;
  endtask
  initial begin
    checks = 0;
    failures = 0;
    clk = 0;
    reset = 1;
    q.flush = 0;
    q.enq_valid = 0;
    q.enq = '0;
    q.wb_valid = 0;
    q.wb_rob = 0;
    q.wb_value = 0;
    q.issue_en = 0;
    #12;
    chk("rst_valid", q.valid, 4'b0000);
    chk("rst_count", q.count, 3'd0);
    chk("rst_ready", q.enq_ready, 1'b1);
    chk("rst_src0_value", q.src0_value, 128'h0);
    reset = 0;
    put(4'd1, 4'd5, 1'b0, 32'h0, 4'd0, 1'b1, 32'h11); tick();
    chk("enq1_valid", q.valid, 4'b0001);
    chk("enq1_count", q.count, 3'd1);
    put(4'd2, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    chk("enq2_valid", q.valid, 4'b0011);
    put(4'd3, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    chk("enq3_valid", q.valid, 4'b0111);
    put(4'd4, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    chk("enq4_valid", q.valid, 4'b1111);
    chk("full_ready", q.enq_ready, 1'b0);
    chk("full_count", q.count, 3'd4);
    chk("full_src0_rdy", q.src0_rdy, 4'b1110);
    put(4'd9, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    chk("drop_valid", q.valid, 4'b1111);
    chk("drop_count", q.count, 3'd4);
    chk("drop_dst", q.dst_rob, 16'h4321);
    q.enq_valid = 0;
    wb(4'd5, 32'hDEADBEEF); tick();
    chk("wake_rdy", q.src0_rdy, 4'b1111);
    chk("wake_value", q.src0_value[31:0], 32'hDEADBEEF);
    wb(4'd5, 32'h1); tick();
    q.wb_valid = 0;
    chk("wake_hold", q.src0_value[31:0], 32'hDEADBEEF);
    q.issue_en = 4'b0100;
    put(4'd7, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    q.issue_en = 0;
    q.enq_valid = 0;
    chk("iss_valid", q.valid, 4'b1011);
    chk("iss_ready", q.enq_ready, 1'b1);
    chk("iss_count", q.count, 3'd3);
    chk("iss_dst", q.dst_rob, 16'h4321);
    put(4'd6, 4'd0, 1'b1, 32'h0, 4'd7, 1'b0, 32'h0);
    wb(4'd7, 32'h12345678); tick();
    q.enq_valid = 0;
    q.wb_valid = 0;
    chk("refill_valid", q.valid, 4'b1111);
    chk("refill_dst", q.dst_rob, 16'h4621);
    chk("byp_rdy", q.src1_rdy, 4'b1111);
    chk("byp_value", q.src1_value[95:64], 32'h12345678);
    q.issue_en = 4'b1000; tick();
    q.issue_en = 0;
    chk("iss3_valid", q.valid, 4'b0111);
    #2 reset = 1;
    #1;
    chk("arst_valid", q.valid, 4'b0000);
    chk("arst_count", q.count, 3'd0);
    chk("arst_ready", q.enq_ready, 1'b1);
    chk("arst_dst", q.dst_rob, 16'h0);
    #2 reset = 0;
    put(4'd10, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    put(4'd11, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    q.enq_valid = 0;
    chk("two_valid", q.valid, 4'b0011);
    chk("two_dst", q.dst_rob, 16'h00BA);
    q.issue_en = 4'b1100; tick();
    q.issue_en = 0;
    chk("iss_invalid", q.valid, 4'b0011);
    q.flush = 1;
    put(4'd12, 4'd0, 1'b1, 32'h0, 4'd0, 1'b1, 32'h0); tick();
    q.flush = 0;
    q.enq_valid = 0;
    chk("flush_valid", q.valid, 4'b0000);
    chk("flush_count", q.count, 3'd0);
    chk("flush_dst", q.dst_rob, 16'h00BA);
    chk("flush_ready", q.enq_ready, 1'b1);
    put(4'd13, 4'd3, 1'b0, 32'h0, 4'd3, 1'b0, 32'h0);
    wb(4'd3, 32'hA5); tick();
    q.enq_valid = 0;
    q.wb_valid = 0;
    chk("byp2_valid", q.valid, 4'b0001);
    chk("byp2_rdy", {q.src0_rdy[0], q.src1_rdy[0]}, 2'b11);
    chk("byp2_v0", q.src0_value[31:0], 32'hA5);
    chk("byp2_v1", q.src1_value[31:0], 32'hA5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_queue_4e.md
Name: issue_queue_4e

Overview:
4-entry issue queue (reservation station) directly upstream of the issue pick/data-mux stage. Accepts one dispatched instruction per cycle into the lowest free slot. Captures writeback values to wake up waiting source operands. Presents all entry state as packed 4-slot buses to the pick stage, and frees slots on the pick stage's per-entry enable.

Parameters:
ROB_W, 4, ROB tag width; 16 ROB entries.
DATA_W, 32, operand and target width.
(Pick stage supports only the defaults; entry count is fixed at 4.)

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
i_flush  in  1  branch-commit override (bco); clears all entries
i_enq_valid  in  1  dispatch presents an instruction
o_enq_ready  out  1  at least one free slot
i_enq_src0_rob  in  4  src0 producer tag
i_enq_src0_rdy  in  1  src0 value already available
i_enq_src0_value  in  32  src0 value (valid when rdy)
i_enq_src1_rob/rdy/value  in  4/1/32  as src0
i_enq_dst_rob  in  4  destination ROB tag
i_enq_branch/load/store  in  1 each  class flags
i_enq_pipe_alu/mul/mem/bru  in  1 each  one-hot pipe select
i_enq_bp_pattern/taken/hit/target  in  2/1/1/32  prediction info
i_wb_valid  in  1  writeback broadcast valid
i_wb_rob  in  4  writeback tag
i_wb_value  in  32  writeback value
i_issue_en  in  4  per-entry issue enable from pick stage (o_en)
o_valid  out  4  entry valid bits
o_src0_rob/rdy/value  out  16/4/128  packed, slot k at [k*W +: W]
o_src1_rob/rdy/value  out  16/4/128  packed
o_dst_rob  out  16  packed
o_branch/load/store  out  4 each
o_pipe_alu/mul/mem/bru  out  4 each
o_bp_pattern/taken/hit/target  out  8/4/4/128
o_count  out  3  number of valid entries (0..4)

Behaviour:
- Reset (async, active-high): all valid, rdy and payload registers = 0. Outputs: o_valid=0, o_count=0, o_enq_ready=1, all buses 0.
- o_enq_ready = ~&valid, computed from registered valid only. A slot freed by i_issue_en this cycle is not reusable until the next cycle.
- Enqueue fires on i_enq_valid & o_enq_ready. It writes the lowest-index free slot and sets valid next cycle. i_enq_valid while not ready is ignored; the payload is dropped and dispatch must hold it.
- Wakeup: each cycle i_wb_valid is compared with every valid entry's src0/src1 tag whose rdy=0. On a match, capture i_wb_value and set rdy=1 at the next edge. Entries with rdy=1 are never overwritten.
- Enqueue bypass: if the enqueued src has rdy=0 and its tag equals i_wb_rob with i_wb_valid in the same cycle, store rdy=1 with i_wb_value. The same rule applies independently to src0 and src1; both may match.
- Issue: i_issue_en[k] clears valid[k] at the next edge; the payload is left stale. An enable on an invalid slot has no effect. Multiple bits may be set at once.
- Flush: i_flush clears all valid bits at the next edge. It takes priority over enqueue (nothing is written) and over wakeup. o_enq_ready is still driven from current state.
- Latency: enqueue to o_valid is 1 cycle; wakeup to rdy is 1 cycle; issue to slot freed is 1 cycle.
- o_count = popcount of registered valid.
- No ordering or age state; pick-stage priority is by slot index.

Decomposition:
- Shared package (issue_pkg): ROB_W, DATA_W, ISSUE_ENTRIES=4, packed-slot index macro/function.
- One natural sub-module: issue_queue_entry. It holds one slot's registers and wakeup compare, with ports for write-enable, clear, flush, wb bus and enqueue payload. The top level instantiates 4 of them plus the lowest-free priority encoder and popcount.

Test Plan:
- Reset mid-run with 3 valid entries: assert reset -> o_valid=0000, o_count=0, o_enq_ready=1 immediately (async).
- Enqueue 4 instructions with dst_rob 1,2,3,4 on back-to-back cycles -> o_valid 0001,0011,0111,1111; o_enq_ready=0; a 5th enqueue is dropped and o_count stays 4.
- Entry 0 src0_rob=5, rdy=0; wb_valid with rob=5, value=0xDEADBEEF -> next cycle o_src0_rdy[0]=1, o_src0_value[31:0]=0xDEADBEEF. A later wb with rob=5 and value=0x1 leaves the value unchanged.
- Enqueue with src1_rob=7, rdy=0 in the same cycle as wb rob=7, value=0x12345678 -> the new slot shows src1_rdy=1, value=0x12345678.
- Full queue with i_issue_en=0100 and i_enq_valid=1 in the same cycle -> enqueue rejected; next cycle o_valid=1011, o_enq_ready=1; the following enqueue lands in slot 2.
- Queue with 2 valid entries; i_flush=1 together with i_enq_valid=1 -> next cycle o_valid=0000, o_count=0.
